fp_alu_arbiter: RTL and testbench
=================================

FP_ALU_ARBITER -- requirements
Module: fp_alu_arbiter

Interface
REQ-001 Parameter: SIN_TIMEOUT, 255, maximum cycles to wait for alu_done on an fsin operation (8-bit range, 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  requester N operation accepted this cycle (one-cycle pulse).
REQ-006 reqN_op  input  3  aluop code: 0 add, 1 sub, 2 mult, 3 abs, 4 slt, 5 sin; 6/7 illegal.
REQ-007 reqN_a, reqN_b  input  32  IEEE-754 single operands.
REQ-008 rsp_valid  output  1  result available; held until rsp_ready.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  index of the requester owning the result.
REQ-011 rsp_data  output  32  result word.
REQ-012 rsp_err  output  1  illegal op or sin timeout.
REQ-013 alu_op  output  3  to FP ALU aluop.
REQ-014 alu_a, alu_b  output  32  to FP ALU a, b.
REQ-015 alu_fsin  output  1  FP ALU sin start pulse.
REQ-016 alu_done  input  1  FP ALU Done (constant 1 for non-sin ops).
REQ-017 alu_res  input  32  FP ALU res.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, WAIT, RESP; one operation in flight at a time.
REQ-019 IDLE: if any reqN_valid, grant one requester, pulse its reqN_ready for that cycle, latch op/a/b/id, go to EXEC; otherwise stay.
REQ-020 Arbitration SHALL be round-robin: when both are valid, the requester not granted last wins; a single valid requester always wins.
REQ-021 At most one reqN_ready SHALL be high in any cycle; reqN_ready SHALL be low outside IDLE.
REQ-022 alu_op/alu_a/alu_b SHALL be driven from the latched request in EXEC and WAIT, and held at zero otherwise.
REQ-023 EXEC, op 0-4: capture alu_res into rsp_data, rsp_err=0, go to RESP (rsp_valid rises 2 cycles after the accept cycle).
REQ-024 EXEC, op 5: assert alu_fsin for exactly this cycle, clear timeout counter, go to WAIT; alu_done is ignored in EXEC.
REQ-025 WAIT: alu_fsin low; on alu_done=1 capture alu_res, rsp_err=0, go to RESP (rsp_valid the cycle after done is sampled).
REQ-026 WAIT timeout: counter increments each WAIT cycle; if it reaches SIN_TIMEOUT without alu_done, rsp_data=32'h7FC00000, rsp_err=1, go to RESP; alu_done in that same cycle takes priority over the timeout.
REQ-027 Illegal op (6/7) in EXEC: rsp_data=0, rsp_err=1, go to RESP, no alu_fsin pulse.
REQ-028 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err stable until the cycle rsp_ready=1; then go to IDLE and update last-grant to rsp_id.
REQ-029 A new request SHALL NOT be accepted in the RESP-exit cycle; the earliest next accept is the following IDLE cycle.
REQ-030 Input changes on reqN_* after accept SHALL NOT affect the in-flight operation.

Reset
REQ-031 While reset is high at a clock edge: state=IDLE, all outputs 0, timeout counter 0, last-grant=1 (requester 0 wins first tie).
REQ-032 Reset asserted mid-operation (EXEC/WAIT/RESP) SHALL abandon it with no response; alu_fsin low the next cycle.

Verification
REQ-033 req0 add a=32'h3F800000 b=32'h40000000 -> req0_ready at T, rsp_valid at T+2, rsp_data=32'h40400000, rsp_id=0, rsp_err=0.
REQ-034 Both valid continuously, op 2 -> grants alternate 0,1,0,1; first grant to 0 after reset.
REQ-035 req1 op 5, model asserts alu_done 10 cycles after alu_fsin with res=32'h3F000000 -> exactly one alu_fsin pulse, rsp_data=32'h3F000000, rsp_id=1, rsp_err=0.
REQ-036 op 5 with alu_done never asserted, SIN_TIMEOUT=4 -> rsp_valid after 4 WAIT cycles, rsp_data=32'h7FC00000, rsp_err=1.
REQ-037 op 7 -> rsp_data=0, rsp_err=1, alu_fsin never high; rsp_ready held low 5 cycles -> rsp_valid/data stable, no new accept.
REQ-038 Reset asserted during WAIT -> next cycle all outputs 0, state IDLE, no rsp_valid; subsequent req0 served normally.

Source files
------------

// File: rtl/fp_alu_arbiter.sv
// fp_alu_arbiter: round-robin front end sharing one FP ALU between two requesters.
// One operation is in flight at a time; fsin operations are supervised by a timeout counter.
module fp_alu_arbiter #(
   parameter int SIN_TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [2:0]  i_req0_op,
   input  logic [31:0] i_req0_a,
   input  logic [31:0] i_req0_b,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [2:0]  i_req1_op,
   input  logic [31:0] i_req1_a,
   input  logic [31:0] i_req1_b,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic        o_rsp_id,
   output logic [31:0] o_rsp_data,
   output logic        o_rsp_err,
   output logic [2:0]  o_alu_op,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   output logic        o_alu_fsin,
   input  logic        i_alu_done,
   input  logic [31:0] i_alu_res
);

   localparam logic [2:0]  LP_OP_SIN  = 3'd5;
   localparam logic [7:0]  LP_TIMEOUT = 8'(SIN_TIMEOUT);
   localparam logic [31:0] LP_QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_last_gnt;
   logic        w_accept;
   logic        w_gnt_id;
   logic [2:0]  w_sel_op;
   logic [31:0] w_sel_a;
   logic [31:0] w_sel_b;
   logic        r_id;
   logic [2:0]  r_alu_op;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic        r_alu_fsin;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_next;
   logic        w_timeout;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_data;
   logic        r_rsp_err;

   function automatic logic f_op_legal(input logic [2:0] op);
      return (op <= 3'd5);
   endfunction

   // Round-robin grant; reset gates the accept so no ready escapes while reset is high.
   always_comb begin
      w_accept = 1'b0;
      w_gnt_id = 1'b0;
      if ((r_state == IDLE) && !i_reset) begin
         if (i_req0_valid && i_req1_valid) begin
            w_accept = 1'b1;
            w_gnt_id = ~r_last_gnt;
         end else if (i_req0_valid) begin
            w_accept = 1'b1;
            w_gnt_id = 1'b0;
         end else if (i_req1_valid) begin
            w_accept = 1'b1;
            w_gnt_id = 1'b1;
         end else begin
            w_accept = 1'b0;
         end
      end else begin
         w_accept = 1'b0;
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      w_sel_op = 3'd0;
      w_sel_a  = 32'd0;
      w_sel_b  = 32'd0;
      if (w_gnt_id) begin
         w_sel_op = i_req1_op;
         w_sel_a  = i_req1_a;
         w_sel_b  = i_req1_b;
      end else begin
         w_sel_op = i_req0_op;
         w_sel_a  = i_req0_a;
         w_sel_b  = i_req0_b;
      end
   end

   assign w_cnt_next = r_cnt + 8'd1;
   assign w_timeout  = (w_cnt_next == LP_TIMEOUT);

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_next = EXEC;
            else          w_state_next = IDLE;
         end
         EXEC: begin
            if (r_alu_op == LP_OP_SIN) w_state_next = WAIT;
            else                       w_state_next = RESP;
         end
         WAIT: begin
            if (i_alu_done || w_timeout) w_state_next = RESP;
            else                         w_state_next = WAIT;
         end
         RESP: begin
            if (i_rsp_ready) w_state_next = IDLE;
            else             w_state_next = RESP;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // Datapath: latch request, drive ALU, capture result, track last grant.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last_gnt  <= 1'b1;
         r_id        <= 1'b0;
         r_alu_op    <= 3'd0;
         r_alu_a     <= 32'd0;
         r_alu_b     <= 32'd0;
         r_alu_fsin  <= 1'b0;
         r_cnt       <= 8'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_id       <= w_gnt_id;
                  r_alu_op   <= w_sel_op;
                  r_alu_a    <= w_sel_a;
                  r_alu_b    <= w_sel_b;
                  r_alu_fsin <= (w_sel_op == LP_OP_SIN);
               end
            end
            EXEC: begin
               r_alu_fsin <= 1'b0;
               r_cnt      <= 8'd0;
               // Non-sin ops finish here; the ALU result is combinational for them.
               if (r_alu_op != LP_OP_SIN) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= f_op_legal(r_alu_op) ? i_alu_res : 32'd0;
                  r_rsp_err   <= ~f_op_legal(r_alu_op);
                  r_alu_op    <= 3'd0;
                  r_alu_a     <= 32'd0;
                  r_alu_b     <= 32'd0;
               end
            end
            WAIT: begin
               r_cnt <= w_cnt_next;
               if (i_alu_done) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= i_alu_res;
                  r_rsp_err   <= 1'b0;
                  r_alu_op    <= 3'd0;
                  r_alu_a     <= 32'd0;
                  r_alu_b     <= 32'd0;
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= LP_QNAN;
                  r_rsp_err   <= 1'b1;
                  r_alu_op    <= 3'd0;
                  r_alu_a     <= 32'd0;
                  r_alu_b     <= 32'd0;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_last_gnt  <= r_id;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_req0_ready = w_accept & ~w_gnt_id;
   assign o_req1_ready = w_accept & w_gnt_id;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_id     = r_id & r_rsp_valid;
   assign o_rsp_data   = r_rsp_data;
   assign o_rsp_err    = r_rsp_err;
   assign o_alu_op     = r_alu_op;
   assign o_alu_a      = r_alu_a;
   assign o_alu_b      = r_alu_b;
   assign o_alu_fsin   = r_alu_fsin;

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Self-checking bench for fp_alu_arbiter with a scoreboard queue and a small FP ALU stand-in.
// A second instance with SIN_TIMEOUT=4 exercises the fsin timeout path.
module tb_fp_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
   logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
   logic        rsp_valid, rsp_id, rsp_err;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [2:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_res;
   logic        alu_fsin, alu_done;

   logic        t_req0_valid = 1'b0, t_req1_valid = 1'b0;
   logic        t_req0_ready, t_req1_ready;
   logic [2:0]  t_req0_op = 3'd0, t_req1_op = 3'd0;
   logic [31:0] t_req0_a = 32'd0, t_req0_b = 32'd0, t_req1_a = 32'd0, t_req1_b = 32'd0;
   logic        t_rsp_valid, t_rsp_id, t_rsp_err;
   logic        t_rsp_ready = 1'b1;
   logic [31:0] t_rsp_data;
   logic [2:0]  t_alu_op;
   logic [31:0] t_alu_a, t_alu_b;
   logic        t_alu_fsin;
   logic        t_alu_done = 1'b0;
   logic [31:0] t_alu_res = 32'hDEAD_BEEF;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int fsin_cnt = 0;
   int sin_cnt = 0;
   int acc_cyc = 0;
   logic        sin_done_en = 1'b0;
   logic [31:0] sin_res = 32'h3F00_0000;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
      logic        err;
   } rsp_t;
   rsp_t exp_q[$];

   fp_alu_arbiter dut (
      .i_clk(clk), .i_reset(reset),
      .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
      .i_req0_a(req0_a), .i_req0_b(req0_b),
      .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
      .i_req1_a(req1_a), .i_req1_b(req1_b),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
      .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
      .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fsin(alu_fsin),
      .i_alu_done(alu_done), .i_alu_res(alu_res)
   );

   fp_alu_arbiter #(.SIN_TIMEOUT(4)) dut_to (
      .i_clk(clk), .i_reset(reset),
      .i_req0_valid(t_req0_valid), .o_req0_ready(t_req0_ready), .i_req0_op(t_req0_op),
      .i_req0_a(t_req0_a), .i_req0_b(t_req0_b),
      .i_req1_valid(t_req1_valid), .o_req1_ready(t_req1_ready), .i_req1_op(t_req1_op),
      .i_req1_a(t_req1_a), .i_req1_b(t_req1_b),
      .o_rsp_valid(t_rsp_valid), .i_rsp_ready(t_rsp_ready), .o_rsp_id(t_rsp_id),
      .o_rsp_data(t_rsp_data), .o_rsp_err(t_rsp_err),
      .o_alu_op(t_alu_op), .o_alu_a(t_alu_a), .o_alu_b(t_alu_b), .o_alu_fsin(t_alu_fsin),
      .i_alu_done(t_alu_done), .i_alu_res(t_alu_res)
   );

   // Stand-in ALU: exact for the 1.0+2.0 case and abs, arbitrary but deterministic otherwise.
   function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : (a ^ b);
         3'd1:    return a - b;
         3'd2:    return {a[31:16], b[15:0]};
         3'd3:    return {1'b0, a[30:0]};
         3'd4:    return {31'd0, (a < b)};
         default: return 32'd0;
      endcase
   endfunction

   assign alu_res  = (alu_op == 3'd5) ? sin_res : alu_model(alu_op, alu_a, alu_b);
   assign alu_done = (alu_op != 3'd5) ? 1'b1 : (sin_done_en && (sin_cnt == 10));

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (alu_fsin) begin
         fsin_cnt <= fsin_cnt + 1;
         sin_cnt  <= 1;
      end else if (sin_cnt != 0 && sin_cnt < 1000) begin
         sin_cnt <= sin_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int   budget;
      logic got;
      budget = 20;
      got = 1'b0;
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      while (!got && budget > 0) begin
         @(negedge clk);
         if ((id ? req1_ready : req0_ready) === 1'b1) begin
            got = 1'b1;
            acc_cyc = cyc;
         end
         budget--;
         @(posedge clk); #1;
      end
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL issue_req%0d: ready got 0 expected 1 within 20 cycles", id);
      end
   endtask

   task automatic drain(input string name);
      int   budget;
      rsp_t e;
      budget = 100;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
               n_err++;
               $display("FAIL %s_rsp: got id=%0d data=%h err=%0d expected id=%0d data=%h err=%0d",
                        name, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
         end
         budget--;
         @(posedge clk); #1;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_drain: got %0d pending responses expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, alu_op, alu_a, alu_b, alu_fsin} !== 104'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got rdy=%b%b vld=%b data=%h op=%h fsin=%b expected all zero",
                  req0_ready, req1_ready, rsp_valid, rsp_data, alu_op, alu_fsin);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      int   g, budget, gid[4], gcyc[4];
      logic both_seen;
      rsp_t e;
      g = 0; budget = 60; both_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) exp_q.push_back({1'b0, alu_model(3'd2, 32'h4000_0000, 32'h4040_1234), 1'b0});
         else            exp_q.push_back({1'b1, alu_model(3'd2, 32'hC100_0000, 32'h3F80_5678), 1'b0});
      end
      rsp_ready = 1'b1;
      req0_op = 3'd2; req0_a = 32'h4000_0000; req0_b = 32'h4040_1234;
      req1_op = 3'd2; req1_a = 32'hC100_0000; req1_b = 32'h3F80_5678;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      while (g < 4 && budget > 0) begin
         @(negedge clk);
         if (req0_ready && req1_ready) both_seen = 1'b1;
         if (req0_ready || req1_ready) begin
            gid[g]  = req1_ready ? 1 : 0;
            gcyc[g] = cyc;
            g++;
         end
         if (rsp_valid === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
               n_err++;
               $display("FAIL rr_rsp: got id=%0d data=%h err=%0d expected id=%0d data=%h err=%0d",
                        rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
         end
         budget--;
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n_cmp++;
      if (g != 4 || both_seen) begin
         n_err++;
         $display("FAIL rr_grants: got %0d grants both_ready=%b expected 4 grants, never both", g, both_seen);
      end
      for (int i = 0; i < g; i++) begin
         n_cmp++;
         if (gid[i] != (i % 2)) begin
            n_err++;
            $display("FAIL rr_order%0d: got requester %0d expected %0d", i, gid[i], i % 2);
         end
         if (i > 0) begin
            n_cmp++;
            if (gcyc[i] - gcyc[i-1] != 3) begin
               n_err++;
               $display("FAIL rr_spacing%0d: got %0d cycles expected 3", i, gcyc[i] - gcyc[i-1]);
            end
         end
      end
      drain("rr");
   endtask

   task automatic test_add();
      rsp_ready = 1'b0;
      exp_q.push_back({1'b0, 32'h4040_0000, 1'b0});
      issue(1'b0, 3'd0, 32'h3F80_0000, 32'h4000_0000);
      req0_a = 32'hFFFF_FFFF;
      req0_op = 3'd6;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || alu_op !== 3'd0 || alu_a !== 32'h3F80_0000 || alu_b !== 32'h4000_0000) begin
         n_err++;
         $display("FAIL add_exec: got vld=%b op=%0d a=%h b=%h expected vld=0 op=0 a=3f800000 b=40000000",
                  rsp_valid, alu_op, alu_a, alu_b);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || (cyc - acc_cyc) != 2 || alu_op !== 3'd0) begin
         n_err++;
         $display("FAIL add_latency: got vld=%b after %0d cycles expected vld=1 after 2", rsp_valid, cyc - acc_cyc);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain("add");
   endtask

   task automatic test_ops();
      logic [2:0]  ops[5] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd2};
      logic [31:0] as[5]  = '{32'h40A0_0000, 32'hC040_0000, 32'h0000_0001, 32'h0000_0005, 32'h1234_5678};
      logic [31:0] bs[5]  = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0002, 32'h0000_0005, 32'h9ABC_DEF0};
      logic        id;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         id = i[0];
         if (ops[i] > 3'd4) exp_q.push_back({id, 32'd0, 1'b1});
         else               exp_q.push_back({id, alu_model(ops[i], as[i], bs[i]), 1'b0});
         issue(id, ops[i], as[i], bs[i]);
         drain("ops");
      end
   endtask

   task automatic test_sin();
      int f0, budget, lat;
      f0 = fsin_cnt;
      lat = -1;
      budget = 40;
      sin_done_en = 1'b1;
      rsp_ready = 1'b0;
      exp_q.push_back({1'b1, 32'h3F00_0000, 1'b0});
      issue(1'b1, 3'd5, 32'h3FC9_0FDB, 32'h0000_0000);
      while (lat < 0 && budget > 0) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) lat = cyc - acc_cyc;
         budget--;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (lat != 12) begin
         n_err++;
         $display("FAIL sin_latency: got %0d cycles expected 12", lat);
      end
      rsp_ready = 1'b1;
      drain("sin");
      n_cmp++;
      if (fsin_cnt - f0 != 1) begin
         n_err++;
         $display("FAIL sin_pulses: got %0d expected 1", fsin_cnt - f0);
      end
      sin_done_en = 1'b0;
   endtask

   task automatic test_timeout();
      int   budget, lat, acc;
      logic got;
      budget = 20; lat = -1; acc = 0; got = 1'b0;
      t_req0_valid = 1'b1; t_req0_op = 3'd5; t_req0_a = 32'h4049_0FDB; t_req0_b = 32'd0;
      while (!got && budget > 0) begin
         @(negedge clk);
         if (t_req0_ready === 1'b1) begin
            got = 1'b1;
            acc = cyc;
         end
         budget--;
         @(posedge clk); #1;
      end
      t_req0_valid = 1'b0;
      budget = 30;
      while (lat < 0 && budget > 0) begin
         @(negedge clk);
         if (t_rsp_valid === 1'b1) begin
            lat = cyc - acc;
            n_cmp++;
            if ({t_rsp_id, t_rsp_data, t_rsp_err} !== {1'b0, 32'h7FC0_0000, 1'b1}) begin
               n_err++;
               $display("FAIL timeout_rsp: got id=%0d data=%h err=%0d expected id=0 data=7fc00000 err=1",
                        t_rsp_id, t_rsp_data, t_rsp_err);
            end
         end
         budget--;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (!got || lat != 6) begin
         n_err++;
         $display("FAIL timeout_latency: got accepted=%b latency=%0d expected accepted=1 latency=6", got, lat);
      end
   endtask

   task automatic test_illegal_stall();
      int   f0, budget;
      logic seen, stable;
      f0 = fsin_cnt; budget = 10; seen = 1'b0; stable = 1'b1;
      rsp_ready = 1'b0;
      exp_q.push_back({1'b0, 32'd0, 1'b1});
      issue(1'b0, 3'd7, 32'h4000_0000, 32'h4000_0000);
      while (!seen && budget > 0) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1'b1;
         budget--;
         @(posedge clk); #1;
      end
      req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'h1; req1_b = 32'h2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_err !== 1'b1 || rsp_id !== 1'b0 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 1'b0;
         @(posedge clk); #1;
      end
      req1_valid = 1'b0;
      n_cmp++;
      if (!seen || !stable) begin
         n_err++;
         $display("FAIL illegal_stall: got seen=%b stable=%b expected seen=1 stable=1", seen, stable);
      end
      rsp_ready = 1'b1;
      drain("illegal");
      n_cmp++;
      if (fsin_cnt != f0) begin
         n_err++;
         $display("FAIL illegal_fsin: got %0d pulses expected 0", fsin_cnt - f0);
      end
   endtask

   task automatic test_reset_mid();
      logic spurious;
      spurious = 1'b0;
      sin_done_en = 1'b0;
      rsp_ready = 1'b1;
      issue(1'b0, 3'd5, 32'h3F80_0000, 32'h0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, alu_op, alu_a, alu_b, alu_fsin} !== 104'd0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got vld=%b op=%0d a=%h fsin=%b expected all zero",
                  rsp_valid, alu_op, alu_a, alu_fsin);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) spurious = 1'b1;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (spurious) begin
         n_err++;
         $display("FAIL reset_mid_norsp: got rsp_valid=1 expected 0 after abandoned op");
      end
      exp_q.push_back({1'b0, 32'h4040_0000, 1'b0});
      issue(1'b0, 3'd0, 32'h3F80_0000, 32'h4000_0000);
      drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_add();
      test_ops();
      test_sin();
      test_timeout();
      test_illegal_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
